// File: rtl/generador_ref_dds_if.sv
// generador_ref_dds_if: valid/ready sample stream of the DDS excitation source.
// With GENERADOR_COSENO_EN defined the stream also carries the quadrature sample.
interface generador_ref_dds_if;
    logic signed [31:0] data_out;
    logic               data_valid;
    logic               data_ready;
    logic               fase_cero;
`ifdef GENERADOR_COSENO_EN
    logic signed [31:0] data_out_coseno;
    modport master (output data_out, data_out_coseno, data_valid, fase_cero, input data_ready);
    modport slave  (input data_out, data_out_coseno, data_valid, fase_cero, output data_ready);
`else
    modport master (output data_out, data_valid, fase_cero, input data_ready);
    modport slave  (input data_out, data_valid, fase_cero, output data_ready);
`endif
endinterface

// File: rtl/generador_ref_dds.sv
// generador_ref_dds: DDS source of amplitud*sin(2*pi*n*phase_inc/2^32) on a valid/ready stream.
// Defining GENERADOR_COSENO_EN adds the aligned quadrature output data_out_coseno.
module generador_ref_dds #(
    parameter int TABLE_BITS = 10,
    parameter int LATENCIA   = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [31:0]         phase_inc,
    input  logic signed [31:0]  amplitud,
    generador_ref_dds_if.master stream
);
    localparam int PROFUNDIDAD = 2 ** TABLE_BITS;
    localparam int CUARTO      = PROFUNDIDAD / 4;
    localparam logic signed [127:0] PI_Q56 = 128'sh3243F6A8885A308;

    // Elaboration-time round(32767*sin(2*pi*k/N)) in Q56 fixed point, folded onto the first quadrant.
    function automatic logic signed [15:0] seno(input int k);
        logic signed [127:0] x, term, sum;
        int r;
        logic neg;
        r = k % CUARTO;
        if (((k / CUARTO) % 2) == 1) r = CUARTO - r;
        neg = (k / CUARTO) >= 2;
        x = (PI_Q56 * 128'(r)) >>> (TABLE_BITS - 1);
        term = x;
        sum = x;
        for (int n = 1; n < 14; n++) begin
            term = -((((term * x) >>> 56) * x) >>> 56) / 128'(4 * n * n + 2 * n);
            sum = sum + term;
        end
        sum = (sum * 128'sd32767 + (128'sd1 <<< 55)) >>> 56;
        return 16'(neg ? -sum : sum);
    endfunction

    logic signed [15:0] tabla [PROFUNDIDAD];
    for (genvar i = 0; i < PROFUNDIDAD; i++) begin : g_tabla
        assign tabla[i] = seno(i);
    end

    logic [31:0]           phase;
    logic [TABLE_BITS-1:0] idx;
    logic signed [31:0]    amp_q;
    logic signed [15:0]    sin_q;
    logic signed [47:0]    prod;
    logic [LATENCIA-1:0]   vld, cero;
    logic                  stall, advance;

    assign idx               = phase[31 -: TABLE_BITS];
    assign stall             = stream.data_valid & ~stream.data_ready;
    assign advance           = enable & ~stall;
    assign stream.data_valid = vld[LATENCIA-1];
    assign stream.fase_cero  = cero[LATENCIA-1];

`ifdef GENERADOR_COSENO_EN
    logic [TABLE_BITS-1:0] idx_c;
    logic signed [15:0]    cos_q;
    logic signed [47:0]    prod_c;

    assign idx_c = idx + TABLE_BITS'(CUARTO);
`endif

    // Issue and table read share the first edge; the phase register is the ROM address register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase           <= '0;
            amp_q           <= '0;
            sin_q           <= '0;
            prod            <= '0;
            vld             <= '0;
            cero            <= '0;
            stream.data_out <= '0;
`ifdef GENERADOR_COSENO_EN
            cos_q                  <= '0;
            prod_c                 <= '0;
            stream.data_out_coseno <= '0;
`endif
        end else if (!enable) begin
            phase <= '0;
            vld   <= '0;
            cero  <= '0;
        end else if (advance) begin
            phase           <= phase + phase_inc;
            amp_q           <= amplitud;
            sin_q           <= tabla[idx];
            prod            <= 48'(amp_q) * 48'(sin_q);
            stream.data_out <= 32'(prod >>> 15);
            vld             <= {vld[LATENCIA-2:0], 1'b1};
            cero            <= {cero[LATENCIA-2:0], idx == '0};
`ifdef GENERADOR_COSENO_EN
            cos_q                  <= tabla[idx_c];
            prod_c                 <= 48'(amp_q) * 48'(cos_q);
            stream.data_out_coseno <= 32'(prod_c >>> 15);
`endif
        end
    end
endmodule

// File: tb/tb_generador_ref_dds.sv
// tb_generador_ref_dds: directed stimulus with a queue scoreboard for generador_ref_dds.
module tb_generador_ref_dds;
    localparam int TB_BITS = 10;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               enable;
    logic [31:0]        phase_inc;
    logic signed [31:0] amplitud;
    logic [31:0]        mphase;
    logic [31:0]        held;
    int                 n_checks = 0;
    int                 n_fail = 0;

    typedef struct {
        logic [31:0] v;
        logic [31:0] c;
        logic        z;
    } exp_t;
    exp_t q[$];

    generador_ref_dds_if s();

    generador_ref_dds #(.TABLE_BITS(TB_BITS), .LATENCIA(3)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable),
        .phase_inc(phase_inc),
        .amplitud (amplitud),
        .stream   (s)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] modelo(input int k, input logic signed [31:0] amp);
        real    v;
        longint sv, p;
        v = 32767.0 * $sin(2.0 * 3.141592653589793 * k / real'(2 ** TB_BITS));
        sv = longint'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
        p = longint'(amp) * sv;
        return 32'(p >>> 15);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard: decides at the negedge what the coming posedge issues and consumes.
    always @(negedge clock) begin
        if (!reset_n) begin
            q.delete();
            mphase = '0;
        end else begin
            if (s.data_valid && s.data_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $error("FAIL sb_empty: observed sample %0d expected none", $signed(s.data_out));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_data", s.data_out, e.v);
                    chk("sb_zero", 32'(s.fase_cero), 32'(e.z));
`ifdef GENERADOR_COSENO_EN
                    chk("sb_cos", s.data_out_coseno, e.c);
`endif
                end
            end
            if (!enable) begin
                q.delete();
                mphase = '0;
            end else if (!(s.data_valid && !s.data_ready)) begin
                exp_t e;
                int   k;
                k = int'(mphase[31 -: TB_BITS]);
                e.v = modelo(k, amplitud);
                e.c = modelo((k + 2 ** (TB_BITS - 2)) % (2 ** TB_BITS), amplitud);
                e.z = (k == 0);
                q.push_back(e);
                mphase = mphase + phase_inc;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        enable = 1'b0;
        s.data_ready = 1'b0;
        phase_inc = '0;
        amplitud = '0;
        #2;
        chk("rst_valid", 32'(s.data_valid), 0);
        chk("rst_data", s.data_out, 0);
        chk("rst_zero", 32'(s.fase_cero), 0);
        step(2);
        reset_n = 1'b1;
        // quadrature waveform
        enable = 1'b1;
        s.data_ready = 1'b1;
        phase_inc = 32'h4000_0000;
        amplitud = 1000;
        step(1);
        chk("lat_edge1", 32'(s.data_valid), 0);
        step(1);
        chk("lat_edge2", 32'(s.data_valid), 0);
        step(1);
        chk("lat_edge3", 32'(s.data_valid), 1);
        chk("quad_s0", s.data_out, 0);
        chk("quad_z0", 32'(s.fase_cero), 1);
`ifdef GENERADOR_COSENO_EN
        chk("quad_c0", s.data_out_coseno, 999);
`endif
        step(1);
        chk("quad_s1", s.data_out, 999);
        chk("quad_z1", 32'(s.fase_cero), 0);
`ifdef GENERADOR_COSENO_EN
        chk("quad_c1", s.data_out_coseno, 0);
`endif
        step(1);
        chk("quad_s2", s.data_out, 0);
        chk("quad_z2", 32'(s.fase_cero), 0);
        step(1);
        chk("quad_s3", s.data_out, -1000);
`ifdef GENERADOR_COSENO_EN
        chk("quad_c3", s.data_out_coseno, 0);
`endif
        step(1);
        chk("quad_s4", s.data_out, 0);
        chk("quad_z4", 32'(s.fase_cero), 1);
        step(4);
        // backpressure
        s.data_ready = 1'b0;
        held = s.data_out;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_hold", s.data_out, held);
            chk("bp_valid", 32'(s.data_valid), 1);
        end
        s.data_ready = 1'b1;
        step(6);
        // enable toggle while stalled
        s.data_ready = 1'b0;
        step(2);
        enable = 1'b0;
        step(1);
        chk("dis_valid", 32'(s.data_valid), 0);
        enable = 1'b1;
        s.data_ready = 1'b1;
        step(3);
        chk("reen_valid", 32'(s.data_valid), 1);
        chk("reen_data", s.data_out, 0);
        chk("reen_zero", 32'(s.fase_cero), 1);
        step(4);
        // extreme amplitude
        enable = 1'b0;
        step(1);
        enable = 1'b1;
        amplitud = 32'sh8000_0000;
        step(3);
        chk("ext_s0", s.data_out, 0);
        step(1);
        chk("ext_s1", s.data_out, -2147418112);
        step(1);
        chk("ext_s2", s.data_out, 0);
        step(1);
        chk("ext_s3", s.data_out, 2147418112);
        // negative step and live amplitude update
        enable = 1'b0;
        step(1);
        enable = 1'b1;
        amplitud = 1000;
        phase_inc = 32'hC000_0000;
        step(3);
        chk("wrap_s0", s.data_out, 0);
        amplitud = 2000;
        step(1);
        chk("wrap_s1", s.data_out, -1000);
        step(1);
        chk("wrap_s2", s.data_out, 0);
        step(1);
        chk("upd_s3", s.data_out, 1999);
        step(2);
        chk("upd_s5", s.data_out, -2000);
        // zero step: constant index-0 stream
        enable = 1'b0;
        step(1);
        enable = 1'b1;
        phase_inc = '0;
        step(5);
        chk("inc0_valid", 32'(s.data_valid), 1);
        chk("inc0_data", s.data_out, 0);
        chk("inc0_zero", 32'(s.fase_cero), 1);
        // asynchronous reset in mid-stream
        phase_inc = 32'h4000_0000;
        step(4);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(s.data_valid), 0);
        chk("arst_data", s.data_out, 0);
        chk("arst_zero", 32'(s.fase_cero), 0);
        step(1);
        reset_n = 1'b1;
        step(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
